pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (legal range 1..256).
REQ-002 The block SHALL have parameter SKID, default 1: 1 selects a 2-entry skid buffer, 0 selects a single-entry register.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream payload present.
REQ-008 in_ready  output  1  stage accepts the payload this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 out_data  output  DATA_W  head entry.
REQ-013 occupancy  output  2  number of held entries (0..2).

Function
REQ-014 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; all transfers SHALL occur only on a fire.
REQ-015 The state SHALL be one of EMPTY (0 entries), ONE (main register full) or TWO (main and skid registers full); TWO SHALL be reachable only when SKID=1.
REQ-016 out_valid SHALL be 1 exactly in ONE or TWO, and out_data SHALL be the main register.
REQ-017 out_data SHALL be all-zero whenever out_valid is 0, so that a bubble carries a zero payload.
REQ-018 With SKID=1, in_ready SHALL be a register output equal to (state != TWO) & !flush, with no combinational path from out_ready.
REQ-019 With SKID=0, in_ready SHALL be (!out_valid | out_ready) & !flush.
REQ-020 Transitions from EMPTY: input fire -> ONE with main <= in_data.
REQ-021 Transitions from ONE: input and output fire -> ONE with main <= in_data; output fire only -> EMPTY with main <= 0; input fire only (SKID=1) -> TWO with skid <= in_data; no fire -> hold.
REQ-022 Transitions from TWO: output fire -> ONE with main <= skid and skid <= 0; no fire -> hold; no input fire is possible in TWO.
REQ-023 Entries SHALL leave in arrival order, with no loss and no duplication.
REQ-024 Latency from input fire into EMPTY to out_valid SHALL be 1 cycle; full throughput of 1 entry/cycle SHALL be sustained while out_ready=1.
REQ-025 flush=1 SHALL override all fires: at the next edge state -> EMPTY, main and skid registers -> 0, and any simultaneous input or output fire SHALL be discarded.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO and SHALL update in the same edge as the state.
REQ-027 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force state EMPTY, out_valid=0, out_data=0, main and skid registers=0, and occupancy=0.
REQ-029 While rst=1, in_ready SHALL be 0; with SKID=1 it SHALL become 1 on the first rising edge after rst is deasserted.
REQ-030 Assertion of rst mid-transfer SHALL discard all held entries with no partial output.

Verification
REQ-031 SKID=1, out_ready=1, stream 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on cycles 1, 2, 3, occupancy stays 1, in_ready stays 1.
REQ-032 SKID=1, out_ready=0, offer 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 are accepted, occupancy=2, in_ready=0, 0xA3 is held upstream; then out_ready=1 -> outputs 0xA1, 0xA2, 0xA3 in order.
REQ-033 SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready equals (!out_valid | out_ready) every cycle, and no entry is lost or duplicated.
REQ-034 State TWO plus flush=1 together with out_ready=1 -> next cycle out_valid=0, out_data=0, occupancy=0, and neither entry is observed downstream.
REQ-035 rst pulsed between clock edges while in state ONE -> out_valid and out_data drop to 0 before the next edge; after release, 0x5A is accepted with 1-cycle latency.
REQ-036 Randomised valid/ready with DATA_W=8 and DATA_W=128 against a FIFO scoreboard -> zero mismatches over 10k cycles, and out_data=0 on every cycle where out_valid=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake. SKID=1 gives a
// 2-entry skid buffer with a registered in_ready; SKID=0 gives a single register.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Handshake: a transfer happens only on a cycle where valid & ready are both
  // high at the rising edge; a producer holding valid must keep its data stable.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end else if (in_fire && (SKID != 0)) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Skid mode: ready is registered from next state so out_ready never reaches
  // in_ready combinationally; it comes up one edge after reset release.
  if (SKID != 0) begin : g_skid
    logic rdy_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= (state_d != ST_TWO);
    end
    assign in_ready = rdy_q & ~flush;
  end else begin : g_reg
    assign in_ready = (~out_valid | out_ready) & ~flush & ~rst;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : '0;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector tables, reset corner
// sequences and a randomised run against a FIFO scoreboard on three configurations.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: DATA_W=8 SKID=1, 1: DATA_W=8 SKID=0, 2: DATA_W=128 SKID=1
  logic         fl[3];
  logic         iv[3];
  logic         orr[3];
  logic [127:0] idat[3];

  logic         ir0, ir1, ir2;
  logic         ov0, ov1, ov2;
  logic [1:0]   oc0, oc1, oc2;
  logic [7:0]   od0, od1;
  logic [127:0] od2;

  pipe_skid_reg #(.DATA_W(8), .SKID(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir0), .in_data(idat[0][7:0]),
    .out_valid(ov0), .out_ready(orr[0]), .out_data(od0), .occupancy(oc0)
  );

  pipe_skid_reg #(.DATA_W(8), .SKID(0)) u_s0 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir1), .in_data(idat[1][7:0]),
    .out_valid(ov1), .out_ready(orr[1]), .out_data(od1), .occupancy(oc1)
  );

  pipe_skid_reg #(.DATA_W(128), .SKID(1)) u_w (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(ir2), .in_data(idat[2]),
    .out_valid(ov2), .out_ready(orr[2]), .out_data(od2), .occupancy(oc2)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic logic get_ir(input int k);
    case (k)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic get_ov(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [127:0] get_od(input int k);
    case (k)
      0:       return {120'b0, od0};
      1:       return {120'b0, od1};
      default: return od2;
    endcase
  endfunction

  function automatic logic [1:0] get_oc(input int k);
    case (k)
      0:       return oc0;
      1:       return oc1;
      default: return oc2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      fl[k]   = 1'b0;
      iv[k]   = 1'b0;
      orr[k]  = 1'b0;
      idat[k] = '0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int           sel;
    logic         fl;
    logic         iv;
    logic [127:0] d;
    logic         orr;
    logic         ir;   // in_ready before the edge
    logic         ov;   // outputs after the edge
    logic [127:0] od;
    logic [1:0]   oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int s, input logic f, input logic v, input logic [127:0] d,
                     input logic r, input logic eir, input logic eov,
                     input logic [127:0] eod, input logic [1:0] eoc);
    vec_t t;
    t.sel = s; t.fl = f; t.iv = v; t.d = d; t.orr = r;
    t.ir = eir; t.ov = eov; t.od = eod; t.oc = eoc;
    vecs.push_back(t);
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    idle_all();
    fl[v.sel]   = v.fl;
    iv[v.sel]   = v.iv;
    idat[v.sel] = v.d;
    orr[v.sel]  = v.orr;
    #1;
    chk($sformatf("v%0d_in_ready", n), {127'b0, get_ir(v.sel)}, {127'b0, v.ir});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_out_valid", n), {127'b0, get_ov(v.sel)}, {127'b0, v.ov});
    chk($sformatf("v%0d_out_data", n), get_od(v.sel), v.od);
    chk($sformatf("v%0d_occupancy", n), {126'b0, get_oc(v.sel)}, {126'b0, v.oc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- FIFO scoreboard for the random run ----------------
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  logic [127:0] exp_q2[$];

  function automatic int qsize(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [127:0] qhead(input int k);
    if (qsize(k) == 0) return '0;
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic model_edge(input int k, output logic exp_ir);
    int   sz;
    logic in_f, out_f;
    sz = qsize(k);
    if (k == 1) exp_ir = ((sz == 0) || orr[k]) && !fl[k];
    else        exp_ir = (sz != 2) && !fl[k];
    in_f  = iv[k] && exp_ir;
    out_f = (sz > 0) && orr[k];
    case (k)
      0: begin
        if (fl[k]) exp_q0.delete();
        else begin
          if (out_f) void'(exp_q0.pop_front());
          if (in_f) exp_q0.push_back(idat[k]);
        end
      end
      1: begin
        if (fl[k]) exp_q1.delete();
        else begin
          if (out_f) void'(exp_q1.pop_front());
          if (in_f) exp_q1.push_back(idat[k]);
        end
      end
      default: begin
        if (fl[k]) exp_q2.delete();
        else begin
          if (out_f) void'(exp_q2.pop_front());
          if (in_f) exp_q2.push_back(idat[k]);
        end
      end
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eir;
    rst = 1'b1;
    idle_all();

    // reset state, asserted over several edges
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", {127'b0, get_ov(k)}, 128'd0);
      chk("rst_out_data", get_od(k), 128'd0);
      chk("rst_occupancy", {126'b0, get_oc(k)}, 128'd0);
      chk("rst_in_ready", {127'b0, get_ir(k)}, 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ir_before_first_edge", {127'b0, ir0}, 128'd0);
    chk("ir_skid0_after_release", {127'b0, ir1}, 128'd1);
    @(posedge clk);
    #1;
    chk("ir_after_first_edge", {127'b0, ir0}, 128'd1);
    chk("ir_wide_after_first_edge", {127'b0, ir2}, 128'd1);

    // SKID=1: streaming, back-pressure, flush in TWO, ignored inputs
    add(0,0,1,'h11,1, 1,1,'h11,1);
    add(0,0,1,'h22,1, 1,1,'h22,1);
    add(0,0,1,'h33,1, 1,1,'h33,1);
    add(0,0,0,'h00,1, 1,0,'h00,0);
    add(0,0,1,'hA1,0, 1,1,'hA1,1);
    add(0,0,1,'hA2,0, 1,1,'hA1,2);
    add(0,0,1,'hA3,0, 0,1,'hA1,2);
    add(0,0,1,'hA3,1, 0,1,'hA2,1);
    add(0,0,1,'hA3,1, 1,1,'hA3,1);
    add(0,0,0,'h00,1, 1,0,'h00,0);
    add(0,0,1,'hB1,0, 1,1,'hB1,1);
    add(0,0,1,'hB2,0, 1,1,'hB1,2);
    add(0,1,1,'hB3,1, 0,0,'h00,0);
    add(0,0,0,'h00,1, 1,0,'h00,0);
    add(0,0,0,'hFF,1, 1,0,'h00,0);
    add(0,0,1,'hC1,0, 1,1,'hC1,1);
    add(0,1,1,'hC2,0, 0,0,'h00,0);
    add(0,0,1,'hD1,0, 1,1,'hD1,1);
    add(0,0,0,'hEE,0, 1,1,'hD1,1);
    add(0,0,0,'h00,1, 1,0,'h00,0);
    // SKID=0: out_ready toggling with continuous in_valid, then flush
    add(1,0,1,'h01,1, 1,1,'h01,1);
    add(1,0,1,'h02,0, 0,1,'h01,1);
    add(1,0,1,'h02,1, 1,1,'h02,1);
    add(1,0,1,'h03,0, 0,1,'h02,1);
    add(1,0,1,'h03,1, 1,1,'h03,1);
    add(1,0,1,'h04,0, 0,1,'h03,1);
    add(1,0,0,'h00,1, 1,0,'h00,0);
    add(1,0,0,'h00,0, 1,0,'h00,0);
    add(1,1,1,'h05,1, 0,0,'h00,0);
    add(1,0,1,'h06,0, 1,1,'h06,1);
    add(1,1,1,'h07,1, 0,0,'h00,0);
    // DATA_W=128 skid fill and drain
    add(2,0,1,128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,0, 1,1,128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,1);
    add(2,0,1,128'h80000000_00000000_00000000_00000001,0, 1,1,128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,2);
    add(2,0,0,128'h0,1, 0,1,128'h80000000_00000000_00000000_00000001,1);
    add(2,0,0,128'h0,1, 1,0,128'h0,0);

    for (int n = 0; n < vecs.size(); n++) apply_vec(vecs[n], n);

    // asynchronous reset mid-cycle while holding an entry
    @(negedge clk);
    idle_all();
    iv[0] = 1'b1; idat[0] = 'h77;
    @(posedge clk);
    #1;
    chk("pre_rst_out_data", get_od(0), 128'h77);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {127'b0, ov0}, 128'd0);
    chk("async_rst_out_data", get_od(0), 128'd0);
    chk("async_rst_occupancy", {126'b0, oc0}, 128'd0);
    chk("async_rst_in_ready", {127'b0, ir0}, 128'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    iv[0] = 1'b1; idat[0] = 'h5A; orr[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_no_fire", {127'b0, ov0}, 128'd0);
    chk("post_rst_in_ready", {127'b0, ir0}, 128'd1);
    @(posedge clk);
    #1;
    chk("post_rst_5a_valid", {127'b0, ov0}, 128'd1);
    chk("post_rst_5a_data", get_od(0), 128'h5A);
    chk("post_rst_5a_occ", {126'b0, oc0}, 128'd1);

    // randomised valid/ready/flush against the scoreboard
    do_reset();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        fl[k]  = ($urandom_range(0, 31) == 0);
        iv[k]  = $urandom_range(0, 1) == 1;
        orr[k] = $urandom_range(0, 2) != 0;
        if (k == 2) idat[k] = {$urandom, $urandom, $urandom, $urandom};
        else        idat[k] = {120'b0, 8'($urandom_range(0, 255))};
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        model_edge(k, eir);
        chk("rnd_in_ready", {127'b0, get_ir(k)}, {127'b0, eir});
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("rnd_out_valid", {127'b0, get_ov(k)}, {127'b0, (qsize(k) > 0)});
        chk("rnd_out_data", get_od(k), qhead(k));
        chk("rnd_occupancy", {126'b0, get_oc(k)}, 128'(qsize(k)));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
